// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline hazard/flush controller.
package pipeline_pkg;

    // Controller modes: normal checking, RAW stall, and the three counted bubble windows.
    typedef enum logic [2:0] {
        CHECK = 3'd0,
        STALL = 3'd1,
        FLUSH = 3'd2,
        INT   = 3'd3,
        RST   = 3'd4
    } hazard_state_t;

    // Decoder instruction-type codes that redirect the PC.
    localparam logic [3:0] INSTR_CALL = 4'h6;
    localparam logic [3:0] INSTR_RET0 = 4'h7;
    localparam logic [3:0] INSTR_RET1 = 4'h8;
    localparam logic [3:0] INSTR_RET2 = 4'h9;

    // PC source selections owned by the hazard unit.
    localparam logic [2:0] PCSEL_MISS = 3'h3;
    localparam logic [2:0] PCSEL_PRED = 3'h4;

    // Operand source selections for the forwarding muxes.
    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_EX = 2'd1;
    localparam logic [1:0] FWD_WB = 2'd2;

    // True for any of the return variants.
    function automatic logic is_return(input logic [3:0] itype);
        return (itype == INSTR_RET0) || (itype == INSTR_RET1) || (itype == INSTR_RET2);
    endfunction

endpackage

// File: rtl/pipeline_hazard_unit_fwd_detect.sv
// Per-operand RAW comparators against the EX and WB destinations, plus the
// forwarding selection each operand should use (EX result wins over WB).
module hazard_fwd_detect
    import pipeline_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int NUM_SRC = 2,
    parameter int FWD_EN  = 1
) (
    input  logic [NUM_SRC*REG_AW-1:0] src_addr,
    input  logic [NUM_SRC-1:0]        src_rd,
    input  logic [REG_AW-1:0]         ex_addr,
    input  logic                      ex_wen,
    input  logic [REG_AW-1:0]         wb_addr,
    input  logic                      wb_wen,
    output logic [NUM_SRC-1:0]        hit_ex,
    output logic [NUM_SRC-1:0]        hit_wb,
    output logic [2*NUM_SRC-1:0]      fwd_sel
);

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        assign hit_ex[i] = src_rd[i] & ex_wen & (src_addr[i*REG_AW +: REG_AW] == ex_addr);
        assign hit_wb[i] = src_rd[i] & wb_wen & (src_addr[i*REG_AW +: REG_AW] == wb_addr);

        // Without forwarding hardware every operand always comes from the regfile.
        assign fwd_sel[2*i +: 2] = (FWD_EN == 0) ? FWD_RF :
                                   hit_ex[i]     ? FWD_EX :
                                   hit_wb[i]     ? FWD_WB : FWD_RF;
    end

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Hazard/flush controller between decode and fetch/PC: resolves RAW hazards by
// forwarding or stalling and inserts counted bubble windows after redirects.
module pipeline_hazard_unit
    import pipeline_pkg::*;
#(
    parameter int REG_AW      = 5,
    parameter int NUM_SRC     = 2,
    parameter int FLUSH_DEPTH = 2,
    parameter int INT_DEPTH   = 3,
    parameter int RST_DEPTH   = 2,
    parameter int FWD_EN      = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_SRC*REG_AW-1:0] src_addr,
    input  logic [NUM_SRC-1:0]        src_rd,
    input  logic [REG_AW-1:0]         ex_addr,
    input  logic                      ex_wen,
    input  logic                      ex_is_load,
    input  logic [REG_AW-1:0]         wb_addr,
    input  logic                      wb_wen,
    input  logic [3:0]                instr_type,
    input  logic [1:0]                instr_pc_mux_sel,
    input  logic                      branch_miss,
    input  logic                      pred_taken,
    input  logic                      interrupt,
    input  logic                      int_en,
    output logic [2*NUM_SRC-1:0]      fwd_sel,
    output logic                      fetch_stall,
    output logic                      imem_addr_hold,
    output logic                      dec_nop,
    output logic                      dec_int,
    output logic                      pc_inc,
    output logic                      pc_load,
    output logic                      pc_reset,
    output logic [2:0]                pc_mux_sel
);

    localparam int MAX_DEPTH = (FLUSH_DEPTH > INT_DEPTH) ?
                               ((FLUSH_DEPTH > RST_DEPTH) ? FLUSH_DEPTH : RST_DEPTH) :
                               ((INT_DEPTH > RST_DEPTH) ? INT_DEPTH : RST_DEPTH);
    localparam int CNT_W = $clog2(MAX_DEPTH) + 1;

    hazard_state_t     state;
    hazard_state_t     state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;

    logic [NUM_SRC-1:0]   hit_ex;
    logic [NUM_SRC-1:0]   hit_wb;
    logic [2*NUM_SRC-1:0] fwd_sel_det;
    logic                 raw_stall;
    logic                 stall_hz;
    logic                 is_call;
    logic                 is_ret;

    hazard_fwd_detect #(
        .REG_AW  (REG_AW),
        .NUM_SRC (NUM_SRC),
        .FWD_EN  (FWD_EN)
    ) u_fwd_detect (
        .src_addr (src_addr),
        .src_rd   (src_rd),
        .ex_addr  (ex_addr),
        .ex_wen   (ex_wen),
        .wb_addr  (wb_addr),
        .wb_wen   (wb_wen),
        .hit_ex   (hit_ex),
        .hit_wb   (hit_wb),
        .fwd_sel  (fwd_sel_det)
    );

    // With forwarding only a load in EX cannot be bypassed; without it any RAW stalls.
    assign raw_stall = (FWD_EN != 0) ? |(hit_ex & {NUM_SRC{ex_is_load}})
                                     : |(hit_ex | hit_wb);

    // After the single load-use bubble the load has moved to WB and is forwarded
    // from there, so the STALL cycle must not re-stall when forwarding is present.
    assign stall_hz = raw_stall & ~((state == STALL) && (FWD_EN != 0));

    assign is_call = (instr_type == INSTR_CALL);
    assign is_ret  = is_return(instr_type);

    // State and bubble counter; reset always parks the controller in the reset window.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RST;
            cnt   <= CNT_W'(RST_DEPTH);
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state selection and all control outputs except the derived PC strobes.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        fetch_stall = 1'b0;
        dec_nop     = 1'b0;
        dec_int     = 1'b0;
        pc_load     = 1'b0;
        pc_mux_sel  = {1'b0, instr_pc_mux_sel};
        fwd_sel     = fwd_sel_det;

        if (reset) begin
            state_nxt  = RST;
            cnt_nxt    = CNT_W'(RST_DEPTH);
            dec_nop    = 1'b1;
            fwd_sel    = '0;
            pc_mux_sel = '0;
        end else begin
            case (state)
                CHECK, STALL: begin
                    if (interrupt && int_en) begin
                        dec_int   = 1'b1;
                        pc_load   = 1'b1;
                        state_nxt = INT;
                        cnt_nxt   = CNT_W'(INT_DEPTH);
                    end else if (stall_hz) begin
                        fetch_stall = 1'b1;
                        dec_nop     = 1'b1;
                        state_nxt   = STALL;
                    end else if (branch_miss) begin
                        pc_mux_sel = PCSEL_MISS;
                        pc_load    = 1'b1;
                        dec_nop    = 1'b1;
                        state_nxt  = FLUSH;
                        cnt_nxt    = CNT_W'(FLUSH_DEPTH);
                    end else if (is_call || is_ret) begin
                        pc_load     = 1'b1;
                        dec_nop     = 1'b1;
                        fetch_stall = is_ret;
                        state_nxt   = FLUSH;
                        cnt_nxt     = CNT_W'(FLUSH_DEPTH);
                    end else if (pred_taken) begin
                        pc_mux_sel  = PCSEL_PRED;
                        pc_load     = 1'b1;
                        fetch_stall = 1'b1;
                        state_nxt   = FLUSH;
                        cnt_nxt     = CNT_W'(1);
                    end else begin
                        state_nxt = CHECK;
                    end
                end
                FLUSH, INT, RST: begin
                    dec_nop = 1'b1;
                    if (branch_miss) begin
                        pc_mux_sel = PCSEL_MISS;
                        pc_load    = 1'b1;
                        state_nxt  = FLUSH;
                        cnt_nxt    = CNT_W'(FLUSH_DEPTH);
                    end else if (cnt <= CNT_W'(1)) begin
                        state_nxt = CHECK;
                    end else begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt = CHECK;
                end
            endcase
        end
    end

    assign imem_addr_hold = fetch_stall;
    assign pc_inc         = ~reset & ~pc_load & ~fetch_stall;
    assign pc_reset       = reset;

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Bench for pipeline_hazard_unit: two instances (forwarding on and off) share
// stimulus; a behavioural model predicts every output each cycle, and directed
// scenarios pin specific values by hand.
module tb_pipeline_hazard_unit;
    localparam int AW = 5;
    localparam int NS = 2;
    localparam int FD = 2;
    localparam int ID = 3;
    localparam int RD = 2;

    typedef struct packed {
        logic [3:0] fwd;
        logic       fs;
        logic       hold;
        logic       nop;
        logic       dint;
        logic       inc;
        logic       load;
        logic       prst;
        logic [2:0] mux;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset;
    logic [NS*AW-1:0] src_addr;
    logic [NS-1:0]    src_rd;
    logic [AW-1:0]    ex_addr;
    logic             ex_wen;
    logic             ex_is_load;
    logic [AW-1:0]    wb_addr;
    logic             wb_wen;
    logic [3:0]       instr_type;
    logic [1:0]       instr_pc_mux_sel;
    logic             branch_miss;
    logic             pred_taken;
    logic             interrupt;
    logic             int_en;

    // Index 1: FWD_EN=1 instance, index 0: FWD_EN=0 instance.
    logic [2*NS-1:0] fwd_sel        [2];
    logic            fetch_stall    [2];
    logic            imem_addr_hold [2];
    logic            dec_nop        [2];
    logic            dec_int        [2];
    logic            pc_inc         [2];
    logic            pc_load        [2];
    logic            pc_reset       [2];
    logic [2:0]      pc_mux_sel     [2];

    int checks = 0;
    int errors = 0;

    pipeline_hazard_unit #(
        .REG_AW(AW), .NUM_SRC(NS), .FLUSH_DEPTH(FD), .INT_DEPTH(ID), .RST_DEPTH(RD), .FWD_EN(1)
    ) dut_fwd (
        .clk(clk), .reset(reset), .src_addr(src_addr), .src_rd(src_rd),
        .ex_addr(ex_addr), .ex_wen(ex_wen), .ex_is_load(ex_is_load),
        .wb_addr(wb_addr), .wb_wen(wb_wen), .instr_type(instr_type),
        .instr_pc_mux_sel(instr_pc_mux_sel), .branch_miss(branch_miss),
        .pred_taken(pred_taken), .interrupt(interrupt), .int_en(int_en),
        .fwd_sel(fwd_sel[1]), .fetch_stall(fetch_stall[1]), .imem_addr_hold(imem_addr_hold[1]),
        .dec_nop(dec_nop[1]), .dec_int(dec_int[1]), .pc_inc(pc_inc[1]), .pc_load(pc_load[1]),
        .pc_reset(pc_reset[1]), .pc_mux_sel(pc_mux_sel[1])
    );

    pipeline_hazard_unit #(
        .REG_AW(AW), .NUM_SRC(NS), .FLUSH_DEPTH(FD), .INT_DEPTH(ID), .RST_DEPTH(RD), .FWD_EN(0)
    ) dut_nofwd (
        .clk(clk), .reset(reset), .src_addr(src_addr), .src_rd(src_rd),
        .ex_addr(ex_addr), .ex_wen(ex_wen), .ex_is_load(ex_is_load),
        .wb_addr(wb_addr), .wb_wen(wb_wen), .instr_type(instr_type),
        .instr_pc_mux_sel(instr_pc_mux_sel), .branch_miss(branch_miss),
        .pred_taken(pred_taken), .interrupt(interrupt), .int_en(int_en),
        .fwd_sel(fwd_sel[0]), .fetch_stall(fetch_stall[0]), .imem_addr_hold(imem_addr_hold[0]),
        .dec_nop(dec_nop[0]), .dec_int(dec_int[0]), .pc_inc(pc_inc[0]), .pc_load(pc_load[0]),
        .pc_reset(pc_reset[0]), .pc_mux_sel(pc_mux_sel[0])
    );

    function automatic exp_t actual(input int k);
        exp_t a;
        a.fwd  = fwd_sel[k];
        a.fs   = fetch_stall[k];
        a.hold = imem_addr_hold[k];
        a.nop  = dec_nop[k];
        a.dint = dec_int[k];
        a.inc  = pc_inc[k];
        a.load = pc_load[k];
        a.prst = pc_reset[k];
        a.mux  = pc_mux_sel[k];
        return a;
    endfunction

    // Reference model: win_left = bubble cycles still owed, lu_prev = the previous
    // cycle was the load-use bubble (forwarding instance only).
    function automatic exp_t model(input int fe, input int win_left, input bit lu_prev,
                                   output int win_n, output bit lu_n);
        exp_t        e;
        logic [NS-1:0] hx;
        logic [NS-1:0] hw;
        bit          raw;
        bit          is_call;
        bit          is_ret;
        e     = '0;
        e.mux = {1'b0, instr_pc_mux_sel};
        win_n = 0;
        lu_n  = 1'b0;
        for (int i = 0; i < NS; i++) begin
            hx[i] = src_rd[i] && ex_wen && (src_addr[i*AW +: AW] == ex_addr);
            hw[i] = src_rd[i] && wb_wen && (src_addr[i*AW +: AW] == wb_addr);
            if (fe != 0) e.fwd[2*i +: 2] = hx[i] ? 2'd1 : (hw[i] ? 2'd2 : 2'd0);
        end
        raw     = (fe != 0) ? ((hx != 0) && ex_is_load) : ((hx != 0) || (hw != 0));
        is_call = (instr_type == 4'd6);
        is_ret  = (instr_type >= 4'd7) && (instr_type <= 4'd9);
        if (reset) begin
            e.nop = 1; e.prst = 1; e.fwd = '0; e.mux = '0; win_n = RD;
        end else if (win_left > 0) begin
            e.nop = 1;
            if (branch_miss) begin e.load = 1; e.mux = 3'd3; win_n = FD; end
            else win_n = win_left - 1;
        end else if (interrupt && int_en) begin
            e.dint = 1; e.load = 1; win_n = ID;
        end else if (raw && !((fe != 0) && lu_prev)) begin
            e.fs = 1; e.nop = 1; lu_n = 1'b1;
        end else if (branch_miss) begin
            e.mux = 3'd3; e.load = 1; e.nop = 1; win_n = FD;
        end else if (is_call || is_ret) begin
            e.load = 1; e.nop = 1; e.fs = is_ret; win_n = FD;
        end else if (pred_taken) begin
            e.mux = 3'd4; e.load = 1; e.fs = 1; win_n = 1;
        end
        e.hold = e.fs;
        e.inc  = !reset && !e.load && !e.fs;
        return e;
    endfunction

    int win_m [2] = '{0, 0};
    bit lu_m  [2] = '{1'b0, 1'b0};

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        exp_t e;
        int   wn;
        bit   ln;
        for (int k = 0; k < 2; k++) begin
            e = model(k, win_m[k], lu_m[k], wn, ln);
            checks++;
            if (actual(k) !== e) begin
                errors++;
                $display("FAIL cycle_cmp dut%0d t=%0t: got %h required %h", k, $time, actual(k), e);
            end
            win_m[k] = wn;
            lu_m[k]  = ln;
        end
    end

    task automatic lit(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic idle();
        src_addr = '0; src_rd = '0; ex_addr = '0; ex_wen = 0; ex_is_load = 0;
        wb_addr = '0; wb_wen = 0; instr_type = '0; instr_pc_mux_sel = '0;
        branch_miss = 0; pred_taken = 0; interrupt = 0; int_en = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        // Reset held across three edges, then a 2-cycle bubble window.
        cyc(); cyc(); #3;
        lit("rst_pc_reset", pc_reset[1], 1);
        lit("rst_dec_nop", dec_nop[1], 1);
        lit("rst_pc_inc", pc_inc[1], 0);
        cyc(); reset = 1'b0; #3;
        lit("rstwin1_nop", dec_nop[1], 1);
        lit("rstwin1_inc", pc_inc[1], 1);
        cyc(); #3;
        lit("rstwin2_nop", dec_nop[1], 1);
        cyc(); #3;
        lit("rstdone_nop", dec_nop[1], 0);
        lit("rstdone_inc", pc_inc[1], 1);

        // Forwarding from EX, then load-use bubble and WB forwarding.
        cyc(); src_addr = 10'd5; src_rd = 2'b01; ex_addr = 5'd5; ex_wen = 1; #3;
        lit("fwd_ex_sel", fwd_sel[1][1:0], 1);
        lit("fwd_ex_nostall", fetch_stall[1], 0);
        cyc(); ex_is_load = 1; #3;
        lit("lu_stall", fetch_stall[1], 1);
        lit("lu_nop", dec_nop[1], 1);
        lit("lu_inc", pc_inc[1], 0);
        cyc(); ex_wen = 0; ex_is_load = 0; wb_addr = 5'd5; wb_wen = 1; #3;
        lit("lu_after_stall", fetch_stall[1], 0);
        lit("lu_after_fwd", fwd_sel[1][1:0], 2);
        cyc(); idle(); #3;

        // No forwarding: WB hit on operand 1 stalls while it persists.
        cyc(); src_addr = {5'd3, 5'd0}; src_rd = 2'b10; wb_addr = 5'd3; wb_wen = 1; #3;
        lit("nofwd_stall", fetch_stall[0], 1);
        lit("nofwd_nop", dec_nop[0], 1);
        lit("nofwd_inc", pc_inc[0], 0);
        lit("nofwd_sel", fwd_sel[0], 0);
        lit("fwd_wb_op1", fwd_sel[1][3:2], 2);
        cyc(); #3;
        lit("nofwd_stall_hold", fetch_stall[0], 1);
        cyc(); idle(); #3;
        lit("nofwd_release", pc_inc[0], 1);

        // Branch miss, with a second miss in the first flush cycle.
        cyc(); branch_miss = 1; #3;
        lit("miss_mux", pc_mux_sel[1], 3);
        lit("miss_load", pc_load[1], 1);
        lit("miss_nop", dec_nop[1], 1);
        lit("miss_inc", pc_inc[1], 0);
        cyc(); #3;
        lit("miss2_load", pc_load[1], 1);
        lit("miss2_nop", dec_nop[1], 1);
        cyc(); branch_miss = 0; #3;
        lit("miss2_win1", dec_nop[1], 1);
        cyc(); #3;
        lit("miss2_win2", dec_nop[1], 1);
        cyc(); #3;
        lit("miss_done_nop", dec_nop[1], 0);
        lit("miss_done_inc", pc_inc[1], 1);

        // Interrupt beats a coincident branch miss; 3 bubbles follow.
        cyc(); interrupt = 1; int_en = 1; branch_miss = 1; #3;
        lit("int_dec_int", dec_int[1], 1);
        lit("int_load", pc_load[1], 1);
        lit("int_mux", pc_mux_sel[1], 0);
        cyc(); idle(); #3;
        lit("int_win1", dec_nop[1], 1);
        cyc(); #3;
        lit("int_win2", dec_nop[1], 1);
        cyc(); #3;
        lit("int_win3", dec_nop[1], 1);
        cyc(); #3;
        lit("int_done", dec_nop[1], 0);

        // Predicted-taken twice: only the first redirects.
        cyc(); pred_taken = 1; #3;
        lit("pred_mux", pc_mux_sel[1], 4);
        lit("pred_load", pc_load[1], 1);
        lit("pred_stall", fetch_stall[1], 1);
        cyc(); #3;
        lit("pred2_mux", pc_mux_sel[1], 0);
        lit("pred2_inc", pc_inc[1], 1);
        cyc(); idle(); #3;
        lit("pred_done_nop", dec_nop[1], 0);

        // Return: PC load through decoder select, fetch held.
        cyc(); instr_type = 4'h8; instr_pc_mux_sel = 2'd2; #3;
        lit("ret_load", pc_load[1], 1);
        lit("ret_stall", fetch_stall[1], 1);
        lit("ret_mux", pc_mux_sel[1], 2);
        cyc(); idle(); cyc(); cyc();

        // Reset in the middle of a flush window.
        cyc(); branch_miss = 1;
        cyc(); branch_miss = 0; reset = 1; #3;
        lit("midrst_reset", pc_reset[1], 1);
        lit("midrst_load", pc_load[1], 0);
        cyc(); reset = 0; #3;
        lit("midrst_win", dec_nop[1], 1);

        // Randomised traffic.
        for (int n = 0; n < 4000; n++) begin
            cyc();
            reset            = ($urandom_range(0, 199) == 0);
            src_addr         = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            src_rd           = 2'($urandom_range(0, 3));
            ex_addr          = 5'($urandom_range(0, 3));
            ex_wen           = 1'($urandom_range(0, 1));
            ex_is_load       = 1'($urandom_range(0, 1));
            wb_addr          = 5'($urandom_range(0, 3));
            wb_wen           = 1'($urandom_range(0, 1));
            instr_type       = 4'($urandom_range(0, 15));
            instr_pc_mux_sel = 2'($urandom_range(0, 3));
            branch_miss      = ($urandom_range(0, 11) == 0);
            pred_taken       = ($urandom_range(0, 5) == 0);
            interrupt        = ($urandom_range(0, 15) == 0);
            int_en           = 1'($urandom_range(0, 1));
        end
        cyc(); idle();
        repeat (3) cyc();
        #3;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
